node_skid_buffer: RTL
=====================

NODE_SKID_BUFFER -- requirements
Module: node_skid_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port data_in  input  WIDTH  upstream payload.
REQ-006 SHALL have port up_valid_in  input  1  upstream valid.
REQ-007 SHALL have port up_ready_out  output  1  ready to upstream, driven directly from a flop.
REQ-008 SHALL have port data_out  output  WIDTH  downstream payload, driven directly from a flop.
REQ-009 SHALL have port dn_valid_out  output  1  downstream valid, driven directly from a flop.
REQ-010 SHALL have port dn_ready_in  input  1  downstream ready.
REQ-011 SHALL have port stat_clr  input  1  synchronous clear of stall_cnt.
REQ-012 SHALL have port occupancy  output  2  entries held (0..2).
REQ-013 SHALL have port stall_cnt  output  CNT_W  saturating count of downstream back-pressure cycles.

Function
REQ-014 SHALL define up_fire = up_valid_in & up_ready_out and dn_fire = dn_valid_out & dn_ready_in.
REQ-015 SHALL implement FSM states EMPTY (0 entries), BUSY (1 entry in main reg), FULL (main reg plus skid reg).
REQ-016 SHALL transition from EMPTY to BUSY on up_fire, loading the main reg; otherwise it SHALL stay EMPTY.
REQ-017 In BUSY:
- up_fire & !dn_fire SHALL go to FULL and load the skid reg.
- up_fire & dn_fire SHALL stay BUSY and load the main reg.
- !up_fire & dn_fire SHALL go to EMPTY.
- Otherwise it SHALL hold.
REQ-018 In FULL, dn_fire SHALL go to BUSY with main reg <= skid reg; otherwise it SHALL hold.
REQ-019 up_ready_out SHALL be registered as (next_state != FULL).
REQ-020 dn_valid_out SHALL be registered as (next_state != EMPTY).
REQ-021 data_out SHALL equal the main reg.
REQ-022 Latency SHALL be 1 cycle: a beat accepted in cycle N is presented in cycle N+1 when the block was EMPTY.
REQ-023 Sustained throughput SHALL be 1 beat per cycle when dn_ready_in is held high.
REQ-024 data_out and dn_valid_out SHALL remain stable while dn_valid_out & !dn_ready_in.
REQ-025 up_valid_in SHALL be ignored while up_ready_out is low; no beat is dropped, duplicated or reordered.
REQ-026 Only one dn_ready_in deassertion of skid SHALL be absorbed: a single beat accepted in the cycle ready drops lands in the skid reg.
REQ-027 occupancy SHALL read 0, 1 and 2 for EMPTY, BUSY and FULL respectively.
REQ-028 stall_cnt SHALL increment each cycle with dn_valid_out & !dn_ready_in and SHALL saturate at all-ones.
REQ-029 stat_clr SHALL zero stall_cnt next cycle, with priority over increment.
REQ-030 Simultaneous dn_fire and up_fire in FULL SHALL be impossible by construction; an assertion SHALL flag it.

Reset
REQ-031 rst high SHALL immediately force state EMPTY, up_ready_out 0, dn_valid_out 0, data_out 0, skid reg 0, occupancy 0 and stall_cnt 0.
REQ-032 up_ready_out SHALL rise on the first clock edge after rst deasserts.
REQ-033 rst asserted mid-transfer SHALL discard all held beats, with no output glitch beyond the forced reset values.

Structure
REQ-034 State enum node_skid_state_t {EMPTY, BUSY, FULL} SHALL live in shared package node_pkg.
REQ-035 The saturating counter SHALL be sub-module node_sat_counter (params CNT_W; ports clk, rst, clr, inc, count).
REQ-036 The payload path SHALL contain exactly two WIDTH-bit registers: main and skid.

Verification (WIDTH=8)
REQ-037 Reset release, then up_valid_in=1, data_in=0x11, dn_ready_in=1 -> data_out=0x11, dn_valid_out=1 one cycle later, occupancy=1.
REQ-038 Stream 0x01..0x10 with dn_ready_in=1 -> 16 beats out in order on consecutive cycles, up_ready_out never low.
REQ-039 BUSY holding 0xA0, dn_ready_in drops while 0xA1 offered -> FULL, up_ready_out=0, data_out stays 0xA0; ready restored -> 0xA0 then 0xA1 out.
REQ-040 dn_ready_in=0 for 70000 cycles with CNT_W=16 and data valid -> stall_cnt=0xFFFF, held; stat_clr pulse -> 0x0000.
REQ-041 rst asserted in FULL -> dn_valid_out=0, up_ready_out=0, occupancy=0 asynchronously; after release, first new beat 0x55 exits unchanged.
REQ-042 Random valid/ready (50%) over 10000 beats -> scoreboard matches in-order data, no loss or duplication, data_out stable under stall.

Source files
------------

// File: rtl/node_pkg.sv
// Shared types for the node skid buffer: FSM state encoding and an
// occupancy helper that maps each state to its entry count.
package node_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } node_skid_state_t;

  function automatic logic [1:0] occ_of(input node_skid_state_t s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/node_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module node_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Counter register: clear, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/node_skid_buffer_chk.sv
// Protocol checker: upstream and downstream handshakes can never both
// complete while the buffer is FULL, because up_ready_out is low there.
module node_skid_buffer_chk
  import node_pkg::*;
(
  input logic             clk,
  input logic             rst,
  input node_skid_state_t state,
  input logic             up_fire,
  input logic             dn_fire
);

  a_no_dual_fire_in_full: assert property (
    @(posedge clk) disable iff (rst)
    !((state == FULL) && up_fire && dn_fire)
  ) else $error("dual fire in FULL state");

endmodule

// File: rtl/node_skid_buffer.sv
// Two-entry skid buffer (main + skid register) with fully registered
// handshake outputs, occupancy report and a saturating stall counter.
module node_skid_buffer
  import node_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_valid_in,
  output logic             up_ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             dn_valid_out,
  input  logic             dn_ready_in,
  input  logic             stat_clr,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  node_skid_state_t state_r;
  node_skid_state_t state_nxt_s;

  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             up_ready_r;
  logic             dn_valid_r;
  logic [1:0]       occ_r;

  logic up_fire_s;
  logic dn_fire_s;
  logic load_main_s;
  logic main_from_skid_s;
  logic load_skid_s;
  logic stall_s;

  assign up_fire_s = up_valid_in & up_ready_r;
  assign dn_fire_s = dn_valid_r & dn_ready_in;
  assign stall_s   = dn_valid_r & ~dn_ready_in;

  // Next-state and payload load decode.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_s      = 1'b0;
    main_from_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (up_fire_s) begin
          state_nxt_s = BUSY;
          load_main_s = 1'b1;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      BUSY: begin
        if (up_fire_s && !dn_fire_s) begin
          state_nxt_s = FULL;
          load_skid_s = 1'b1;
        end else if (up_fire_s && dn_fire_s) begin
          state_nxt_s = BUSY;
          load_main_s = 1'b1;
        end else if (dn_fire_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      FULL: begin
        // up_ready is low here, so only the drain path can happen.
        if (dn_fire_s) begin
          state_nxt_s      = BUSY;
          load_main_s      = 1'b1;
          main_from_skid_s = 1'b1;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // State and registered handshake/occupancy outputs, all derived from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= EMPTY;
      up_ready_r <= 1'b0;
      dn_valid_r <= 1'b0;
      occ_r      <= 2'd0;
    end else begin
      state_r    <= state_nxt_s;
      up_ready_r <= (state_nxt_s != FULL);
      dn_valid_r <= (state_nxt_s != EMPTY);
      occ_r      <= occ_of(state_nxt_s);
    end
  end

  // Main payload register, refilled from upstream or promoted from skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r <= {WIDTH{1'b0}};
    end else if (load_main_s) begin
      main_r <= main_from_skid_s ? skid_r : data_in;
    end else begin
      main_r <= main_r;
    end
  end

  // Skid register catches the beat accepted in the cycle downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_r <= {WIDTH{1'b0}};
    end else if (load_skid_s) begin
      skid_r <= data_in;
    end else begin
      skid_r <= skid_r;
    end
  end

  assign up_ready_out = up_ready_r;
  assign dn_valid_out = dn_valid_r;
  assign data_out     = main_r;
  assign occupancy    = occ_r;

  node_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (stall_s),
    .count (stall_cnt)
  );

  node_skid_buffer_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .state   (state_r),
    .up_fire (up_fire_s),
    .dn_fire (dn_fire_s)
  );

endmodule
